axis_lfsr_checker: RTL and testbench
====================================

Name: axis_lfsr_checker

Overview:
- AXI-Stream sink that sits directly downstream of the AXI-Lite-controlled LFSR generator and consumes its m_axis stream.
- Locks onto the first accepted beat as the seed and predicts each following beat with the same 8-bit Fibonacci recurrence as the generator.
- Counts beats and mismatches, captures the first bad word, and measures the sequence period.
- Used as the on-chip self-check for the generator in simulation and bring-up.

Parameters:
DATA_WIDTH, 32, stream data width; bits [7:0] carry LFSR state and bits [DATA_WIDTH-1:8] must be zero.
CNT_WIDTH, 16, width of the word, error and period counters.

Ports:
aclk  input  1  single clock; all logic on rising edge.
aresetn  input  1  synchronous, active-low reset.
s_axis_tdata  input  DATA_WIDTH  stream data from the LFSR generator.
s_axis_tvalid  input  1  stream valid.
s_axis_tready  output  1  stream ready.
taps  input  8  tap mask; must match the generator's taps register.
enable  input  1  1 = accept beats; 0 = stall the stream and hold all state.
clear  input  1  single-cycle synchronous clear of counters and lock.
locked  output  1  seed has been captured.
word_count  output  CNT_WIDTH  accepted beats since lock, including the seed beat; saturates at all-ones.
error_count  output  CNT_WIDTH  mismatching beats; saturates at all-ones.
error  output  1  sticky; set on the first mismatch.
first_error_data  output  DATA_WIDTH  tdata of the first mismatching beat.
period  output  CNT_WIDTH  measured sequence period.
period_valid  output  1  period holds a measured value.

Behaviour:
- Beat accepted when s_axis_tvalid && s_axis_tready at a rising edge.
- s_axis_tready = aresetn & enable & ~clear (combinational). It is 0 during reset and during clear, so a beat is never accepted in a clear cycle.
- Reset (aresetn=0 at edge): state=SEED, and all outputs are 0: locked, word_count, error_count, error, first_error_data, period, period_valid. Internal seed and expected registers are also 0.
- Next-state function: next(x) = {x[6:0], ^(x & taps)}, evaluated with the current taps input.
- State SEED (locked=0), on beat:
  - seed <= tdata[7:0]; expected <= next(tdata[7:0]).
  - word_count <= 1; locked <= 1; go to TRACK.
  - The seed beat is never an error, even if the upper bits are non-zero.
- State TRACK (locked=1), on beat:
  - match = (tdata[7:0]==expected) && (tdata[DATA_WIDTH-1:8]==0).
  - word_count increments (saturating).
  - expected <= next(tdata[7:0]) on both match and mismatch. After a mismatch the checker resyncs to the received value.
  - On mismatch: error_count increments (saturating). If error==0, then first_error_data <= tdata and error <= 1.
  - Period: on a matching beat with tdata[7:0]==seed and period_valid==0, period <= word_count (the pre-increment value) and period_valid <= 1. Further recurrences do not update period.
- Latency: every counter and flag reflects a beat on the cycle after its acceptance edge.
- No beat in a cycle: all state holds.
- enable=0: no acceptance and state holds; TRACK resumes with the same expected value.
- clear=1: state=SEED. locked, word_count, error_count, error, first_error_data, period and period_valid all go to 0. clear has priority over everything except reset.
- All-zero seed with any taps: next(0)=0, so a stream of zeros matches, and period=1 is recorded on the second beat.
- Saturated word_count: counting stops. A recurrence after saturation reports period=all-ones.
- Taps change mid-stream: applies to the next prediction only. No retroactive check.

Test Plan:
- Reset, taps=0x8E, beats 0x01,0x02,0x05,0x0B,0x16 with tvalid held high and enable=1 -> locked=1, word_count=5, error_count=0, error=0.
- Same taps, beats 0x01,0x02,0x07,0x0E -> error_count=1, error=1, first_error_data=0x00000007, 0x0E matches after resync, word_count=4.
- taps=0x80, beats 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80,0x01 -> period=8, period_valid=1, error_count=0, word_count=9.
- Locked with expected 0x02, send 0x00000102 -> mismatch counted, first_error_data=0x00000102, error=1.
- Mid-stream stall: enable=0 for 5 cycles with tvalid=1 -> tready=0 and counters frozen. Then re-enable and send the correct next value -> no error.
- clear pulse after 3 beats -> all counters 0 and locked=0, tready=0 in the clear cycle. Next beat 0x05 becomes the seed and word_count=1.

Source files
------------

// File: rtl/axis_lfsr_checker.sv
// AXI-Stream sink that locks onto an 8-bit Fibonacci LFSR stream and checks it.
// Tracks beat/mismatch counts, the first bad word and the sequence period.
module axis_lfsr_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [7:0]            taps,
    input  logic                  enable,
    input  logic                  clear,
    output logic                  locked,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] first_error_data,
    output logic [CNT_WIDTH-1:0]  period,
    output logic                  period_valid
);

    typedef enum logic {
        SEED,
        TRACK
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [7:0]              seed_q, seed_d;
    logic [7:0]              exp_q, exp_d;
    logic [CNT_WIDTH-1:0]    wc_q, wc_d;
    logic [CNT_WIDTH-1:0]    ec_q, ec_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   fed_q, fed_d;
    logic [CNT_WIDTH-1:0]    per_q, per_d;
    logic                    pv_q, pv_d;

    logic       beat;
    logic       match;
    logic [7:0] lo;
    logic [7:0] nxt;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x, input logic [7:0] t);
        return {x[6:0], ^(x & t)};
    endfunction

    assign s_axis_tready = aresetn & enable & ~clear;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign lo            = s_axis_tdata[7:0];
    assign nxt           = lfsr_next(lo, taps);
    assign match         = (lo == exp_q) && (s_axis_tdata[DATA_WIDTH-1:8] == '0);

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        exp_d   = exp_q;
        wc_d    = wc_q;
        ec_d    = ec_q;
        err_d   = err_q;
        fed_d   = fed_q;
        per_d   = per_q;
        pv_d    = pv_q;
        if (clear) begin
            state_d = SEED;
            wc_d    = '0;
            ec_d    = '0;
            err_d   = 1'b0;
            fed_d   = '0;
            per_d   = '0;
            pv_d    = 1'b0;
        end else if (beat) begin
            exp_d = nxt;
            unique case (state_q)
                SEED: begin
                    seed_d  = lo;
                    wc_d    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d = TRACK;
                end
                TRACK: begin
                    if (wc_q != CNT_MAX)
                        wc_d = wc_q + 1'b1;
                    if (!match) begin
                        if (ec_q != CNT_MAX)
                            ec_d = ec_q + 1'b1;
                        if (!err_q) begin
                            err_d = 1'b1;
                            fed_d = s_axis_tdata;
                        end
                    end else if (lo == seed_q && !pv_q) begin
                        // Pre-increment count = beats from seed up to its return
                        per_d = wc_q;
                        pv_d  = 1'b1;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= SEED;
            seed_q  <= '0;
            exp_q   <= '0;
            wc_q    <= '0;
            ec_q    <= '0;
            err_q   <= 1'b0;
            fed_q   <= '0;
            per_q   <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            exp_q   <= exp_d;
            wc_q    <= wc_d;
            ec_q    <= ec_d;
            err_q   <= err_d;
            fed_q   <= fed_d;
            per_q   <= per_d;
            pv_q    <= pv_d;
        end
    end

    assign locked           = (state_q == TRACK);
    assign word_count       = wc_q;
    assign error_count      = ec_q;
    assign error            = err_q;
    assign first_error_data = fed_q;
    assign period           = per_q;
    assign period_valid     = pv_q;

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Directed self-checking bench for axis_lfsr_checker.
// Expected values are hand-computed LFSR sequences.
module tb_axis_lfsr_checker;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic [7:0]    taps;
    logic          enable;
    logic          clear;
    logic          locked;
    logic [CW-1:0] word_count;
    logic [CW-1:0] error_count;
    logic          error;
    logic [DW-1:0] first_error_data;
    logic [CW-1:0] period;
    logic          period_valid;

    int checks = 0;
    int errors = 0;

    axis_lfsr_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axis_tdata     (tdata),
        .s_axis_tvalid    (tvalid),
        .s_axis_tready    (tready),
        .taps             (taps),
        .enable           (enable),
        .clear            (clear),
        .locked           (locked),
        .word_count       (word_count),
        .error_count      (error_count),
        .error            (error),
        .first_error_data (first_error_data),
        .period           (period),
        .period_valid     (period_valid)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        tdata  = d;
        tvalid = 1'b1;
        @(posedge aclk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic do_clear();
        clear  = 1'b1;
        tvalid = 1'b1;
        tdata  = 32'h99;
        #1;
        chk("clr_tready", tready, 0);
        @(posedge aclk);
        #1;
        clear  = 1'b0;
        tvalid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        tdata   = '0;
        tvalid  = 1'b0;
        taps    = 8'h8E;
        enable  = 1'b1;
        clear   = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_ec", error_count, 0);
        chk("rst_err", error, 0);
        chk("rst_fed", first_error_data, 0);
        chk("rst_per", period, 0);
        chk("rst_pv", period_valid, 0);
        aresetn = 1'b1;
        #1;
        chk("tready_up", tready, 1);

        // Clean run with taps 0x8E
        send(32'h01);
        chk("a_locked", locked, 1);
        chk("a_wc1", word_count, 1);
        send(32'h02);
        send(32'h05);
        send(32'h0B);
        send(32'h16);
        chk("a_wc", word_count, 5);
        chk("a_ec", error_count, 0);
        chk("a_err", error, 0);

        do_clear();
        chk("c_locked", locked, 0);
        chk("c_wc", word_count, 0);

        // One bad beat then resync
        send(32'h01);
        send(32'h02);
        send(32'h07);
        chk("b_ec1", error_count, 1);
        chk("b_err", error, 1);
        chk("b_fed", first_error_data, 32'h7);
        send(32'h0E);
        chk("b_ec_resync", error_count, 1);
        chk("b_wc", word_count, 4);

        // Stall with tvalid high; next expected is 0x1D
        enable = 1'b0;
        tvalid = 1'b1;
        tdata  = 32'h1D;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s_tready", tready, 0);
            @(posedge aclk);
            #1;
            chk("s_wc", word_count, 4);
        end
        enable = 1'b1;
        send(32'h1D);
        send(32'h3A);
        chk("s_ec", error_count, 1);
        chk("s_wc2", word_count, 6);

        // Non-zero upper bits are a mismatch
        do_clear();
        send(32'h01);
        send(32'h102);
        chk("u_ec", error_count, 1);
        chk("u_err", error, 1);
        chk("u_fed", first_error_data, 32'h102);
        chk("u_wc", word_count, 2);

        // Rotation sequence, period 8
        do_clear();
        taps = 8'h80;
        send(32'h01);
        send(32'h02);
        send(32'h04);
        send(32'h08);
        send(32'h10);
        send(32'h20);
        send(32'h40);
        send(32'h80);
        chk("p_pv0", period_valid, 0);
        send(32'h01);
        chk("p_per", period, 8);
        chk("p_pv", period_valid, 1);
        chk("p_ec", error_count, 0);
        chk("p_wc", word_count, 9);
        send(32'h02);
        send(32'h04);
        send(32'h08);
        do_clear();
        chk("k_locked", locked, 0);
        chk("k_wc", word_count, 0);
        chk("k_per", period, 0);
        chk("k_pv", period_valid, 0);
        send(32'h05);
        chk("k_locked1", locked, 1);
        chk("k_wc1", word_count, 1);

        // Zero seed with dirty upper bits: seed is never an error
        do_clear();
        taps = 8'h8E;
        send(32'hFF00_0000);
        chk("z_err", error, 0);
        send(32'h00);
        chk("z_per", period, 1);
        chk("z_pv", period_valid, 1);
        chk("z_wc", word_count, 2);
        chk("z_ec", error_count, 0);

        // Saturation of word_count, late recurrence reports all-ones
        do_clear();
        taps = 8'h00;
        send(32'h80);
        tdata  = 32'h0;
        tvalid = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge aclk);
        #1;
        tvalid = 1'b0;
        chk("sat_wc", word_count, 16'hFFFF);
        chk("sat_pv0", period_valid, 0);
        chk("sat_ec0", error_count, 0);
        send(32'h40);
        chk("sat_ec1", error_count, 1);
        send(32'h80);
        chk("sat_per", period, 16'hFFFF);
        chk("sat_pv", period_valid, 1);
        chk("sat_wc2", word_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
